// File: rtl/downcounter.sv
// Loadable down-counter/timer with start/busy handshake and a registered zero tick.
// Optional periodic mode is selected by defining DOWNCOUNTER_AUTORELOAD_EN.
module downcounter #(
    parameter int COUNT_BITS = 3,
    parameter int START      = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  load,
    input  logic [COUNT_BITS-1:0] load_value,
    input  logic                  start,
    output logic [COUNT_BITS-1:0] count,
    output logic                  zero_tick,
    output logic                  busy
);

    localparam logic [COUNT_BITS-1:0] START_C = COUNT_BITS'(START);
    localparam logic [COUNT_BITS-1:0] ZERO_C  = COUNT_BITS'(0);
    localparam logic [COUNT_BITS-1:0] ONE_C   = COUNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [COUNT_BITS-1:0]   reload_r;
    logic [COUNT_BITS-1:0]   reload_nxt_s;
    logic [COUNT_BITS-1:0]   count_nxt_s;
    logic                    tick_nxt_s;
    logic                    busy_nxt_s;

    // Next-state, next-count and next-output decode with load > start > enable priority.
    always_comb begin
        state_nxt_s  = state_r;
        reload_nxt_s = reload_r;
        count_nxt_s  = count;
        tick_nxt_s   = 1'b0;

        if (load) begin
            reload_nxt_s = load_value;
            count_nxt_s  = load_value;
            state_nxt_s  = (load_value != ZERO_C) ? ST_RUN : ST_DONE;
        end else if (start) begin
            count_nxt_s  = reload_r;
            state_nxt_s  = (reload_r != ZERO_C) ? ST_RUN : ST_DONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_nxt_s = count;
                end
                ST_RUN: begin
                    if (enable) begin
                        if (count > ONE_C) begin
                            count_nxt_s = count - ONE_C;
                        end else if (count == ONE_C) begin
                            count_nxt_s = ZERO_C;
                            tick_nxt_s  = 1'b1;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
                            state_nxt_s = ST_RUN;
`else
                            state_nxt_s = ST_DONE;
`endif
                        end else begin
`ifdef DOWNCOUNTER_AUTORELOAD_EN
                            // Zero reached on the previous enabled cycle: start the next period.
                            count_nxt_s = reload_r;
                            state_nxt_s = ST_RUN;
`else
                            count_nxt_s = ZERO_C;
                            state_nxt_s = ST_DONE;
`endif
                        end
                    end else begin
                        count_nxt_s = count;
                    end
                end
                ST_DONE: begin
                    count_nxt_s = ZERO_C;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = START_C;
                end
            endcase
        end

        busy_nxt_s = (state_nxt_s == ST_RUN);
    end

    // State, reload value and all outputs registered; async reset restores START.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            reload_r  <= START_C;
            count     <= START_C;
            zero_tick <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            reload_r  <= reload_nxt_s;
            count     <= count_nxt_s;
            zero_tick <= tick_nxt_s;
            busy      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_downcounter.sv
// Self-checking bench for downcounter: directed test-plan sequences plus random
// stimulus compared against a timer-level reference model.
module tb_downcounter;

    localparam int CB    = 3;
    localparam int START = 5;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic          load;
    logic [CB-1:0] load_value;
    logic          start;
    logic [CB-1:0] count;
    logic          zero_tick;
    logic          busy;

    int n_checks;
    int n_fail;

    // Reference model: a timer that is either running or not, with a remaining count.
    int m_count;
    int m_reload;
    bit m_running;
    bit m_tick;

    downcounter #(.COUNT_BITS(CB), .START(START)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .count     (count),
        .zero_tick (zero_tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count   = START;
        m_reload  = START;
        m_running = 1'b0;
        m_tick    = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit en, input int v);
        m_tick = 1'b0;
        if (ld) begin
            m_reload  = v;
            m_count   = v;
            m_running = (v != 0);
        end else if (st) begin
            m_count   = m_reload;
            m_running = (m_reload != 0);
        end else if (m_running && en) begin
            if (m_count == 0) begin
                m_count = m_reload;       // only reachable in periodic mode
            end else begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_tick = 1'b1;
`ifndef DOWNCOUNTER_AUTORELOAD_EN
                    m_running = 1'b0;
`endif
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".tick"},  int'(zero_tick), int'(m_tick));
        check({tag, ".busy"},  int'(busy), int'(m_running));
    endtask

    // Drive one cycle, advance the model and compare outputs #1 after the edge.
    task automatic cyc(input string tag, input bit ld, input bit st, input bit en, input int v);
        load       = ld;
        start      = st;
        enable     = en;
        load_value = CB'(v);
        @(posedge clk);
        #1;
        model_step(ld, st, en, v);
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; enable = 1'b0; load_value = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.count", int'(count), 5);
        check("reset.tick",  int'(zero_tick), 0);
        check("reset.busy",  int'(busy), 0);
        resetn = 1'b1;

        // Enable without arming: stays IDLE at START.
        for (int i = 0; i < 4; i++) cyc("idle_en", 1'b0, 1'b0, 1'b1, 0);
        check("idle.count", int'(count), 5);

`ifndef DOWNCOUNTER_AUTORELOAD_EN
        // One-shot from reload register.
        begin
            int exp_seq [6] = '{5, 4, 3, 2, 1, 0};
            for (int i = 0; i < 6; i++) begin
                cyc("oneshot", 1'b0, (i == 0), 1'b1, 0);
                check("oneshot.seq", int'(count), exp_seq[i]);
                check("oneshot.tick", int'(zero_tick), int'(exp_seq[i] == 0));
                check("oneshot.busy", int'(busy), int'(exp_seq[i] != 0));
            end
            for (int i = 0; i < 3; i++) cyc("oneshot_hold", 1'b0, 1'b0, 1'b1, 0);
            check("oneshot.hold", int'(count), 0);
        end

        // Pause with enable low.
        begin
            int  exp_seq [7] = '{3, 2, 2, 2, 2, 1, 0};
            bit  en_seq  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            int  ticks = 0;
            for (int i = 0; i < 7; i++) begin
                cyc("pause", (i == 0), 1'b0, en_seq[i], 3);
                check("pause.seq", int'(count), exp_seq[i]);
                ticks += int'(zero_tick);
            end
            check("pause.ticks", ticks, 1);
            check("pause.last_tick", int'(zero_tick), 1);
        end

        // Priority: load beats start and enable during RUN at count 2.
        cyc("prio_arm", 1'b1, 1'b0, 1'b0, 4);
        cyc("prio_dec", 1'b0, 1'b0, 1'b1, 0);
        cyc("prio_dec", 1'b0, 1'b0, 1'b1, 0);
        check("prio.pre", int'(count), 2);
        cyc("prio", 1'b1, 1'b1, 1'b1, 6);
        check("prio.count", int'(count), 6);
        check("prio.busy", int'(busy), 1);
`endif

        // Zero load then start from a zero reload: DONE without a tick.
        cyc("zload", 1'b1, 1'b0, 1'b1, 0);
        check("zload.count", int'(count), 0);
        check("zload.busy", int'(busy), 0);
        check("zload.tick", int'(zero_tick), 0);
        cyc("zstart", 1'b0, 1'b1, 1'b1, 0);
        check("zstart.busy", int'(busy), 0);
        check("zstart.tick", int'(zero_tick), 0);

`ifdef DOWNCOUNTER_AUTORELOAD_EN
        // Periodic mode: load 2 with enable held.
        begin
            int exp_seq [6] = '{2, 1, 0, 2, 1, 0};
            for (int i = 0; i < 6; i++) begin
                cyc("auto", (i == 0), 1'b0, 1'b1, 2);
                check("auto.seq", int'(count), exp_seq[i]);
                check("auto.tick", int'(zero_tick), int'(exp_seq[i] == 0));
                check("auto.busy", int'(busy), 1);
            end
            cyc("auto", 1'b0, 1'b0, 1'b1, 0);
        end
`endif

        // Asynchronous reset mid-RUN takes effect without a clock edge.
        cyc("mid_arm", 1'b1, 1'b0, 1'b1, 7);
        cyc("mid_run", 1'b0, 1'b0, 1'b1, 0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_rst.count", int'(count), 5);
        check("async_rst.busy",  int'(busy), 0);
        check("async_rst.tick",  int'(zero_tick), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc("post_rst_start", 1'b0, 1'b1, 1'b0, 0);
        check("post_rst.reload", int'(count), 5);

        // Random traffic against the model, with occasional async resets.
        for (int i = 0; i < 400; i++) begin
            bit ld = ($urandom_range(9, 0) == 0);
            bit st = ($urandom_range(11, 0) == 0);
            bit en = ($urandom_range(9, 0) < 7);
            int v  = int'($urandom_range(7, 0));
            if ($urandom_range(79, 0) == 0) begin
                #2;
                resetn = 1'b0;
                #1;
                model_reset();
                compare_model("rnd_rst");
                @(posedge clk);
                #1;
                resetn = 1'b1;
            end
            cyc("rnd", ld, st, en, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
